// File: rtl/hash_b64_out.sv
// hash_b64_out: streams a captured bcrypt result as the 60-character ASCII
// string "$2b$CC$" + 22 salt chars + 31 hash chars, one byte per
// valid/ready transfer. A private copy of the result is kept so the
// upstream stage may reset as soon as the capture handshake completes.
// Optional build macro: HASH_B64_NUL_EN appends a NUL byte at index 60.
module hash_b64_out #(
    parameter logic [7:0] VARIANT = 8'h62
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic [325:0] hash,
    input  logic         hash_valid,
    output logic         hash_ready,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         done
);

`ifdef HASH_B64_NUL_EN
    localparam logic [5:0] LAST_IDX = 6'd60;
`else
    localparam logic [5:0] LAST_IDX = 6'd59;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFIX,
        S_COST,
        S_SEP,
        S_SALT,
        S_HASH,
        S_TERM,
        S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [5:0]     idx_q, idx_d;
    logic [5:0]     cost_q;
    logic [185:0]   sh_q, sh_d;     // active radix-64 section, MSB-aligned
    logic [183:0]   hq_q;           // ctext[191:8], loaded into sh_q at 28->29
    logic [7:0]     out_data_q, char_d;
    logic           out_valid_q, busy_q, done_q;

    // ctext[7:0] never appears in the output string.
    logic unused_ctext_lsb;
    assign unused_ctext_lsb = ^hash[7:0];

    function automatic logic [7:0] b64_char(input logic [5:0] v);
        if (v < 6'd2)
            return 8'h2E + {2'b00, v};
        else if (v < 6'd28)
            return 8'h41 + {2'b00, v - 6'd2};
        else if (v < 6'd54)
            return 8'h61 + {2'b00, v - 6'd28};
        else
            return 8'h30 + {2'b00, v - 6'd54};
    endfunction

    // Next index, next shift-register contents and the character/state it selects
    always_comb begin
        idx_d = idx_q + 6'd1;
        sh_d  = sh_q;
        if (idx_q == 6'd28)
            sh_d = {hq_q, 2'b00};
        else if ((idx_q >= 6'd7 && idx_q <= 6'd27) || (idx_q >= 6'd29 && idx_q <= 6'd58))
            sh_d = sh_q << 6;

        if (idx_d <= 6'd3) begin
            state_d = S_PREFIX;
            case (idx_d)
                6'd1:    char_d = 8'h32;
                6'd2:    char_d = VARIANT;
                default: char_d = 8'h24;
            endcase
        end else if (idx_d <= 6'd5) begin
            state_d = S_COST;
            char_d  = (idx_d == 6'd4) ? 8'h30 + {2'b00, cost_q / 6'd10}
                                      : 8'h30 + {2'b00, cost_q % 6'd10};
        end else if (idx_d == 6'd6) begin
            state_d = S_SEP;
            char_d  = 8'h24;
        end else if (idx_d <= 6'd28) begin
            state_d = S_SALT;
            char_d  = b64_char(sh_d[185:180]);
        end else if (idx_d <= 6'd59) begin
            state_d = S_HASH;
            char_d  = b64_char(sh_d[185:180]);
        end else begin
            state_d = S_TERM;
            char_d  = 8'h00;
        end
    end

    // Control FSM with registered outputs; async reset aborts any stream in flight
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cost_q      <= '0;
            sh_q        <= '0;
            hq_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (hash_valid) begin
                        cost_q      <= hash[325:320];
                        sh_q        <= {hash[319:192], 58'd0};
                        hq_q        <= hash[191:8];
                        idx_q       <= '0;
                        out_data_q  <= 8'h24;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_PREFIX;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    if (out_ready) begin
                        if (idx_q == LAST_IDX) begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b0;
                            out_data_q  <= '0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            idx_q      <= idx_d;
                            sh_q       <= sh_d;
                            out_data_q <= char_d;
                            state_q    <= state_d;
                        end
                    end
                end
            endcase
        end
    end

    assign hash_ready = (state_q == S_IDLE);
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_hash_b64_out.sv
// Testbench for hash_b64_out: randomized results checked against a
// string-level model of the bcrypt output format.
module tb_hash_b64_out;

`ifdef HASH_B64_NUL_EN
    localparam int EXP_LEN = 61;
`else
    localparam int EXP_LEN = 60;
`endif

    logic         clk = 1'b0;
    logic         rst_l = 1'b0;
    logic [325:0] hash = '0;
    logic         hash_valid = 1'b0;
    logic         hash_ready;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    hash_b64_out #(.VARIANT(8'h62)) dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .hash       (hash),
        .hash_valid (hash_valid),
        .hash_ready (hash_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int viol, ndone, ncyc, hr_bad;
    bit tmo;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected string from the format rules: prefix, decimal cost, radix-64 sections
    task automatic build_expected(input logic [5:0] c, input logic [127:0] s, input logic [191:0] t);
        string alpha = "./ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789";
        logic [131:0] sv;
        logic [185:0] hv;
        int v;
        exp_q.delete();
        exp_q.push_back(8'h24); exp_q.push_back(8'h32);
        exp_q.push_back(8'h62); exp_q.push_back(8'h24);
        v = int'(c);
        exp_q.push_back(8'(8'h30 + v / 10));
        exp_q.push_back(8'(8'h30 + v % 10));
        exp_q.push_back(8'h24);
        sv = {s, 4'b0000};
        for (int i = 0; i < 22; i++) begin
            v = int'(sv[131 - 6*i -: 6]);
            exp_q.push_back(alpha[v]);
        end
        hv = {t[191:8], 2'b00};
        for (int i = 0; i < 31; i++) begin
            v = int'(hv[185 - 6*i -: 6]);
            exp_q.push_back(alpha[v]);
        end
`ifdef HASH_B64_NUL_EN
        exp_q.push_back(8'h00);
`endif
    endtask

    function automatic int str_diff();
        int d = 0;
        if (got_q.size() != exp_q.size()) d++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) d++;
        return d;
    endfunction

    task automatic capture(input logic [5:0] c, input logic [127:0] s, input logic [191:0] t, output bit ok);
        hash = {c, s, t};
        hash_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (hash_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) tick();
        hash_valid = 1'b0;
    endtask

    // Drain one string; records bytes, stall-stability violations and done pulses
    task automatic collect(input bit stall7, input bit rnd, input int pulse_at, input int abort_at);
        int stall = 0;
        bit stalled7 = 1'b0;
        bit pulsed = 1'b0;
        bit pend = 1'b0;
        logic [7:0] pdata = '0;
        got_q.delete();
        viol = 0; ndone = 0; ncyc = 0; hr_bad = 0; tmo = 1'b0;
        while (got_q.size() < EXP_LEN) begin
            if (ncyc >= 3000) begin
                tmo = 1'b1;
                break;
            end
            if (abort_at >= 0 && got_q.size() == abort_at) begin
                rst_l = 1'b0;
                out_ready = 1'b0;
                return;
            end
            if (!out_valid) viol++;
            if (pend && out_data !== pdata) viol++;
            if (stall7 && !stalled7 && got_q.size() == 7) begin
                stall = 10;
                stalled7 = 1'b1;
            end
            if (stall > 0) begin
                out_ready = 1'b0;
                stall--;
            end else if (rnd) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                out_ready = 1'b1;
            end
            if (pulse_at >= 0 && !pulsed && got_q.size() == pulse_at) begin
                hash = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                        $urandom, $urandom, $urandom, $urandom, $urandom};
                hash_valid = 1'b1;
                pulsed = 1'b1;
                if (hash_ready) hr_bad++;
            end else begin
                hash_valid = 1'b0;
            end
            if (out_valid && out_ready) got_q.push_back(out_data);
            pend = out_valid && !out_ready;
            pdata = out_data;
            tick();
            ncyc++;
            if (done) ndone++;
        end
        hash_valid = 1'b0;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [191:0] rnd192();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        #3;
        tests_run++;
        if ({out_valid, busy, done, out_data} !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got v=%b b=%b d=%b data=%h, need all 0", out_valid, busy, done, out_data);
        end
        tick(); tick();
        rst_l = 1'b1;
        tick();
        tests_run++;
        if (hash_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_hash_ready: got %b, need 1", hash_ready);
        end
    endtask

    task automatic test_zero();
        bit ok;
        build_expected(6'd5, '0, '0);
        capture(6'd5, '0, '0, ok);
        tests_run++;
        if (!ok || out_valid !== 1'b1 || busy !== 1'b1 || out_data !== 8'h24) begin
            tests_failed++;
            $display("FAIL zero_latency: got ok=%b v=%b busy=%b data=%h, need 1 1 1 24", ok, out_valid, busy, out_data);
        end
        collect(1'b0, 1'b0, -1, -1);
        tests_run++;
        if (tmo || str_diff() != 0) begin
            tests_failed++;
            $display("FAIL zero_string: got %0d bad positions (timeout=%b), need 0", str_diff(), tmo);
        end
        tests_run++;
        if (ncyc != EXP_LEN || viol != 0) begin
            tests_failed++;
            $display("FAIL zero_consecutive: got %0d cycles, %0d gaps, need %0d cycles, 0 gaps", ncyc, viol, EXP_LEN);
        end
        tests_run++;
        if (done !== 1'b1 || ndone != 1 || busy !== 1'b0 || out_valid !== 1'b0 || hash_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_done: got done=%b n=%0d busy=%b v=%b rdy=%b, need 1 1 0 0 0", done, ndone, busy, out_valid, hash_ready);
        end
        tick();
        tests_run++;
        if (done !== 1'b0 || hash_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_after_done: got done=%b rdy=%b, need 0 1", done, hash_ready);
        end
    endtask

    task automatic test_ones();
        bit ok;
        build_expected(6'd31, '1, '1);
        capture(6'd31, '1, '1, ok);
        collect(1'b0, 1'b0, -1, -1);
        tests_run++;
        if (!ok || tmo || str_diff() != 0) begin
            tests_failed++;
            $display("FAIL ones_string: got %0d bad positions (ok=%b timeout=%b), need 0", str_diff(), ok, tmo);
        end
        tests_run++;
        if (got_q.size() > 59 && (got_q[28] !== 8'h75 || got_q[59] !== 8'h36)) begin
            tests_failed++;
            $display("FAIL ones_tail_chars: got %h %h, need 75 36", got_q[28], got_q[59]);
        end
        tick();
    endtask

    task automatic test_cost_digits();
        logic [5:0] costs[3] = '{6'd4, 6'd10, 6'd63};
        logic [7:0] tens[3] = '{8'h30, 8'h31, 8'h36};
        logic [7:0] units[3] = '{8'h34, 8'h30, 8'h33};
        logic [127:0] s;
        logic [191:0] t;
        bit ok;
        for (int unsigned k = 0; k < 3; k++) begin
            s = rnd128();
            t = rnd192();
            build_expected(costs[k], s, t);
            capture(costs[k], s, t, ok);
            collect(1'b0, 1'b0, -1, -1);
            tests_run++;
            if (!ok || tmo || got_q.size() < 6 || got_q[4] !== tens[k] || got_q[5] !== units[k]) begin
                tests_failed++;
                $display("FAIL cost_digits_%0d: got size %0d (ok=%b tmo=%b), need digits %h %h", costs[k], got_q.size(), ok, tmo, tens[k], units[k]);
            end
            tests_run++;
            if (str_diff() != 0) begin
                tests_failed++;
                $display("FAIL cost_string_%0d: got %0d bad positions, need 0", costs[k], str_diff());
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] s;
        logic [191:0] t;
        logic [5:0] c;
        bit ok;
        for (int unsigned k = 0; k < 3; k++) begin
            s = rnd128();
            t = rnd192();
            c = 6'($urandom_range(0, 63));
            build_expected(c, s, t);
            capture(c, s, t, ok);
            collect(1'b1, 1'b1, -1, -1);
            tests_run++;
            if (!ok || tmo || viol != 0) begin
                tests_failed++;
                $display("FAIL bp_stable_%0d: got %0d stall violations (ok=%b tmo=%b), need 0", k, viol, ok, tmo);
            end
            tests_run++;
            if (str_diff() != 0) begin
                tests_failed++;
                $display("FAIL bp_string_%0d: got %0d bad positions, need 0", k, str_diff());
            end
            out_ready = 1'b1;
            tick();
        end
    endtask

    task automatic test_hash_ignored();
        logic [127:0] s;
        logic [191:0] t;
        bit ok;
        s = rnd128();
        t = rnd192();
        build_expected(6'd12, s, t);
        capture(6'd12, s, t, ok);
        collect(1'b0, 1'b0, 20, -1);
        tests_run++;
        if (!ok || tmo || hr_bad != 0 || str_diff() != 0) begin
            tests_failed++;
            $display("FAIL ignore_string: got %0d bad positions, rdy-high %0d, need 0 0", str_diff(), hr_bad);
        end
        // back-to-back: capture on the first cycle hash_ready returns
        tick();
        tests_run++;
        if (hash_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_ready: got %b, need 1", hash_ready);
        end
        s = rnd128();
        t = rnd192();
        build_expected(6'd27, s, t);
        capture(6'd27, s, t, ok);
        tests_run++;
        if (!ok || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_capture: got ok=%b v=%b, need 1 1", ok, out_valid);
        end
        collect(1'b0, 1'b1, -1, -1);
        tests_run++;
        if (tmo || str_diff() != 0) begin
            tests_failed++;
            $display("FAIL b2b_string: got %0d bad positions, need 0", str_diff());
        end
        tick();
    endtask

    task automatic test_reset_midstream();
        logic [127:0] s;
        logic [191:0] t;
        bit ok;
        s = rnd128();
        t = rnd192();
        capture(6'd9, s, t, ok);
        collect(1'b0, 1'b0, -1, 35);
        #1;
        tests_run++;
        if (!ok || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_outputs: got v=%b busy=%b done=%b (ok=%b), need 0 0 0", out_valid, busy, done, ok);
        end
        tick(); tick();
        rst_l = 1'b1;
        tick();
        tests_run++;
        if (hash_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_recover: got rdy=%b v=%b, need 1 0", hash_ready, out_valid);
        end
        s = rnd128();
        t = rnd192();
        build_expected(6'd48, s, t);
        capture(6'd48, s, t, ok);
        collect(1'b0, 1'b1, -1, -1);
        tests_run++;
        if (!ok || tmo || str_diff() != 0) begin
            tests_failed++;
            $display("FAIL abort_next_string: got %0d bad positions (ok=%b), need 0", str_diff(), ok);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_zero();
        test_ones();
        test_cost_digits();
        test_backpressure();
        test_hash_ignored();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
